decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- RV64I decode stage directly downstream of the fetch stage; consumes the fetch latch (DE_NPC, DE_IR, DE_V).
- Decodes each instruction, generates the immediate, reads the integer register file and tracks in-flight writers with a per-register scoreboard.
- Raises V_DEP_STALL and V_DE_FE_BR_STALL back to fetch, and drives the DE→EXE pipeline latch.

Parameters:
- XLEN, 64, datapath and register width.
- SB_CNT_W, 2, width of each scoreboard pending-writer counter; holds up to 3 in flight (EXE, MEM, WB).

Ports:
- CLK  in  1  clock, all state updates on posedge.
- RESET_N  in  1  synchronous active-low reset, sampled at posedge CLK.
- DE_NPC  in  64  PC+4 of the instruction in the fetch latch.
- DE_IR  in  32  instruction word.
- DE_V  in  1  fetch-latch valid.
- WB_V  in  1  writeback valid.
- WB_DR  in  5  writeback destination register.
- WB_DATA  in  64  writeback data.
- V_DEP_STALL  out  1  RAW hazard; fetch holds PC and the fetch latch.
- V_DE_FE_BR_STALL  out  1  control-flow instruction in decode; fetch holds PC and sends a bubble.
- EXE_V  out  1  EXE latch valid.
- EXE_NPC  out  64  registered DE_NPC.
- EXE_IR  out  32  registered DE_IR.
- EXE_SR1  out  64  rs1 operand.
- EXE_SR2  out  64  rs2 operand.
- EXE_IMM  out  64  sign-extended immediate.
- EXE_DR  out  5  destination register.
- EXE_WE  out  1  instruction writes EXE_DR.

Behaviour:
- Reset (RESET_N=0 at posedge):
  - All EXE_* outputs go to 0.
  - All 32 scoreboard counters and all 32 registers go to 0.
  - WB_V is ignored in the reset cycle.
  - Reset mid-operation discards all in-flight tracking.
- Field decode (combinational from DE_IR): opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
- Immediates, all sign-extended to 64 bits:
  - I-type: LOAD, OP-IMM, OP-IMM-32, JALR.
  - S-type: STORE.
  - B-type: BRANCH, bit 0 = 0.
  - U-type: LUI, AUIPC; imm[31:12] followed by 12 zeros, then sign-extended.
  - J-type: JAL, bit 0 = 0.
  - Any other opcode: 0.
- Operand use:
  - uses_rs1 for every opcode except LUI, AUIPC, JAL.
  - uses_rs2 for OP, OP-32, STORE, BRANCH.
- Write enable: we = opcode in {LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, OP-IMM-32, OP-32} and rd≠0.
- Register file:
  - x0 always reads 0 and writes to it are dropped.
  - Write on posedge when WB_V=1.
  - Reads are write-first: if WB_V=1 and WB_DR equals the source register (≠0), the read returns WB_DATA that same cycle.
- Scoreboard:
  - cnt[r] is incremented when an instruction with we=1 issues to EXE.
  - cnt[r] is decremented on WB_V for WB_DR≠0.
  - Simultaneous increment and decrement of the same register: unchanged.
  - x0 counter is held at 0.
- Effective busy: busy(r) = cnt[r]≠0 and not (WB_V and WB_DR==r and cnt[r]==1).
- V_DEP_STALL = DE_V and ((uses_rs1 and busy(rs1)) or (uses_rs2 and busy(rs2))). Combinational, no latency.
- V_DE_FE_BR_STALL = DE_V and opcode in {BRANCH, JAL, JALR}, asserted regardless of V_DEP_STALL.
- Issue: at posedge, EXE_V ← DE_V and not V_DEP_STALL.
  - When issuing, all other EXE_* load the decoded values.
  - When not issuing, EXE_V=0, the other EXE_* hold, and the scoreboard does not increment.
- Latency: fetch latch to EXE latch is 1 cycle when no hazard.
- Back-to-back writers of the same rd without a stall: counter reaches 2 and clears only after both writebacks.

Optional Feature:
- Macro: DECODE_ILLEGAL_CHECK_EN.
- Defined:
  - Adds output EXE_ILLEGAL (1 bit), registered like the other EXE_* outputs and reset to 0.
  - Set when the opcode is outside the RV64I base set, or when DE_IR[1:0]≠2'b11.
  - An illegal instruction issues with EXE_WE=0, V_DEP_STALL=0 and V_DE_FE_BR_STALL=0.
- Undefined:
  - No EXE_ILLEGAL port.
  - Unknown opcodes issue with EXE_WE=0, EXE_IMM=0 and no stalls.

Test Plan:
- Reset: hold RESET_N=0 two cycles with DE_V=1 → EXE_V=0, all EXE_*=0, and after release reading x5 returns 0.
- Immediates: `ADDI x1,x0,-1` (0xFFF00093) → EXE_IMM=0xFFFFFFFFFFFFFFFF, EXE_DR=1, EXE_WE=1. `LUI x2,0x80000` → EXE_IMM=0xFFFFFFFF80000000.
- RAW stall: issue `ADDI x1,x0,5`, then `ADD x3,x1,x1` next cycle.
  - V_DEP_STALL=1 and EXE_V=0 until the cycle WB_V=1 with WB_DR=1 and WB_DATA=5.
  - In that cycle V_DEP_STALL=0, and next cycle EXE_V=1 with EXE_SR1=EXE_SR2=5.
- Double writer: two `ADDI x4` issue back-to-back → cnt[4]=2. After the first WB_V, a reader of x4 still stalls. After the second WB_V, the reader issues with the second value.
- Branch: `BEQ x0,x0,+8` with DE_V=1 → V_DE_FE_BR_STALL=1, V_DEP_STALL=0, and EXE_IMM=8 next cycle.
- x0 hazard: `ADDI x0,x0,1` followed by `ADD x5,x0,x0` → no stall, cnt[0]=0, EXE_SR1=0.

Source files
------------

// File: rtl/decode_stage.sv
// RV64I decode stage: field/immediate decode, write-first register file, per-register
// pending-writer scoreboard, hazard stalls and the DE->EXE latch. Optional: DECODE_ILLEGAL_CHECK_EN.
module decode_stage #(
  parameter int XLEN     = 64,
  parameter int SB_CNT_W = 2
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [XLEN-1:0] DE_NPC,
  input  logic [31:0]     DE_IR,
  input  logic            DE_V,
  input  logic            WB_V,
  input  logic [4:0]      WB_DR,
  input  logic [XLEN-1:0] WB_DATA,
  output logic            V_DEP_STALL,
  output logic            V_DE_FE_BR_STALL,
  output logic            EXE_V,
  output logic [XLEN-1:0] EXE_NPC,
  output logic [31:0]     EXE_IR,
  output logic [XLEN-1:0] EXE_SR1,
  output logic [XLEN-1:0] EXE_SR2,
  output logic [XLEN-1:0] EXE_IMM,
  output logic [4:0]      EXE_DR,
`ifdef DECODE_ILLEGAL_CHECK_EN
  output logic            EXE_ILLEGAL,
`endif
  output logic            EXE_WE
);

  typedef enum logic [6:0] {
    OPC_LOAD      = 7'b0000011,
    OPC_MISC_MEM  = 7'b0001111,
    OPC_OP_IMM    = 7'b0010011,
    OPC_AUIPC     = 7'b0010111,
    OPC_OP_IMM_32 = 7'b0011011,
    OPC_STORE     = 7'b0100011,
    OPC_OP        = 7'b0110011,
    OPC_LUI       = 7'b0110111,
    OPC_OP_32     = 7'b0111011,
    OPC_BRANCH    = 7'b1100011,
    OPC_JALR      = 7'b1100111,
    OPC_JAL       = 7'b1101111,
    OPC_SYSTEM    = 7'b1110011
  } opcode_e;

  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] imm;
  logic            uses_rs1, uses_rs2, we_op, is_cf, de_we, issue;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] regs [32];
  logic [SB_CNT_W-1:0] sb_cnt  [32];
  logic [SB_CNT_W-1:0] sb_next [32];
  logic [31:0]     busy;

  assign opcode = DE_IR[6:0];
  assign rd     = DE_IR[11:7];
  assign rs1    = DE_IR[19:15];
  assign rs2    = DE_IR[24:20];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    imm      = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    we_op    = 1'b0;
    is_cf    = 1'b0;
    unique case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32: begin
        imm      = {{(XLEN-12){DE_IR[31]}}, DE_IR[31:20]};
        uses_rs1 = 1'b1;
        we_op    = 1'b1;
      end
      OPC_JALR: begin
        imm      = {{(XLEN-12){DE_IR[31]}}, DE_IR[31:20]};
        uses_rs1 = 1'b1;
        we_op    = 1'b1;
        is_cf    = 1'b1;
      end
      OPC_STORE: begin
        imm      = {{(XLEN-12){DE_IR[31]}}, DE_IR[31:25], DE_IR[11:7]};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        imm      = {{(XLEN-12){DE_IR[31]}}, DE_IR[7], DE_IR[30:25], DE_IR[11:8], 1'b0};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        is_cf    = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm   = {{(XLEN-32){DE_IR[31]}}, DE_IR[31:12], 12'b0};
        we_op = 1'b1;
      end
      OPC_JAL: begin
        imm   = {{(XLEN-20){DE_IR[31]}}, DE_IR[19:12], DE_IR[20], DE_IR[30:21], 1'b0};
        we_op = 1'b1;
        is_cf = 1'b1;
      end
      OPC_OP, OPC_OP_32: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        we_op    = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: uses_rs1 = 1'b1;
      default: ;  // unknown opcodes decode as a harmless no-op with no stalls
    endcase
  end

  assign de_we = we_op && (rd != 5'd0);

  // Write-first: a same-cycle writeback to the source register bypasses the array.
  always_comb begin
    rs1_val = regs[rs1];
    rs2_val = regs[rs2];
    if (WB_V && WB_DR == rs1) rs1_val = WB_DATA;
    if (WB_V && WB_DR == rs2) rs2_val = WB_DATA;
    if (rs1 == 5'd0) rs1_val = '0;
    if (rs2 == 5'd0) rs2_val = '0;
  end

  // A register whose last pending writer retires this cycle is already free.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      busy[r] = (sb_cnt[r] != '0) &&
                !(WB_V && WB_DR == 5'(r) && sb_cnt[r] == SB_CNT_W'(1));
    end
  end

  assign V_DEP_STALL      = DE_V && ((uses_rs1 && busy[rs1]) || (uses_rs2 && busy[rs2]));
  assign V_DE_FE_BR_STALL = DE_V && is_cf;
  assign issue            = DE_V && !V_DEP_STALL;

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      sb_next[r] = sb_cnt[r]
                 + SB_CNT_W'(issue && de_we && rd == 5'(r))
                 - SB_CNT_W'(WB_V && WB_DR == 5'(r));
    end
    sb_next[0] = '0;
  end

  // NOTE: the register array is reset here because reads of never-written registers must return 0;
  // a plain RAM without reset would not give that guarantee.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      for (int r = 0; r < 32; r++) begin
        regs[r]   <= '0;
        sb_cnt[r] <= '0;
      end
    end else begin
      if (WB_V && WB_DR != 5'd0) regs[WB_DR] <= WB_DATA;
      for (int r = 0; r < 32; r++) sb_cnt[r] <= sb_next[r];
    end
  end

`ifdef DECODE_ILLEGAL_CHECK_EN
  logic de_illegal;
  assign de_illegal = !(opcode inside {OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC,
                                       OPC_OP_IMM_32, OPC_STORE, OPC_OP, OPC_LUI, OPC_OP_32,
                                       OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM});
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      EXE_V   <= 1'b0;
      EXE_NPC <= '0;
      EXE_IR  <= '0;
      EXE_SR1 <= '0;
      EXE_SR2 <= '0;
      EXE_IMM <= '0;
      EXE_DR  <= '0;
      EXE_WE  <= 1'b0;
`ifdef DECODE_ILLEGAL_CHECK_EN
      EXE_ILLEGAL <= 1'b0;
`endif
    end else begin
      EXE_V <= issue;
      if (issue) begin
        EXE_NPC <= DE_NPC;
        EXE_IR  <= DE_IR;
        EXE_SR1 <= rs1_val;
        EXE_SR2 <= rs2_val;
        EXE_IMM <= imm;
        EXE_DR  <= rd;
        EXE_WE  <= de_we;
`ifdef DECODE_ILLEGAL_CHECK_EN
        EXE_ILLEGAL <= de_illegal;
`endif
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: reset, immediates, RAW stall, double writer,
// branch stall, x0 handling and unknown opcodes (also EXE_ILLEGAL when DECODE_ILLEGAL_CHECK_EN).
module tb_decode_stage;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [63:0] DE_NPC;
  logic [31:0] DE_IR;
  logic        DE_V;
  logic        WB_V;
  logic [4:0]  WB_DR;
  logic [63:0] WB_DATA;
  logic        V_DEP_STALL, V_DE_FE_BR_STALL, EXE_V, EXE_WE;
  logic [63:0] EXE_NPC, EXE_SR1, EXE_SR2, EXE_IMM;
  logic [31:0] EXE_IR;
  logic [4:0]  EXE_DR;
`ifdef DECODE_ILLEGAL_CHECK_EN
  logic        EXE_ILLEGAL;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  decode_stage dut (
    .CLK(CLK), .RESET_N(RESET_N), .DE_NPC(DE_NPC), .DE_IR(DE_IR), .DE_V(DE_V),
    .WB_V(WB_V), .WB_DR(WB_DR), .WB_DATA(WB_DATA),
    .V_DEP_STALL(V_DEP_STALL), .V_DE_FE_BR_STALL(V_DE_FE_BR_STALL),
    .EXE_V(EXE_V), .EXE_NPC(EXE_NPC), .EXE_IR(EXE_IR), .EXE_SR1(EXE_SR1),
    .EXE_SR2(EXE_SR2), .EXE_IMM(EXE_IMM), .EXE_DR(EXE_DR),
`ifdef DECODE_ILLEGAL_CHECK_EN
    .EXE_ILLEGAL(EXE_ILLEGAL),
`endif
    .EXE_WE(EXE_WE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the edge; registered outputs are sampled there too.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic present(input logic v, input logic [31:0] ir, input logic [63:0] npc);
    DE_V   = v;
    DE_IR  = ir;
    DE_NPC = npc;
  endtask

  task automatic wb(input logic v, input logic [4:0] dr, input logic [63:0] data);
    WB_V    = v;
    WB_DR   = dr;
    WB_DATA = data;
  endtask

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  initial begin
    // Reset held two cycles with a valid instruction and a writeback that must be ignored.
    RESET_N = 1'b0;
    present(1'b1, 32'hFFF0_0093, 64'h104);
    wb(1'b1, 5'd5, 64'hDEAD);
    #1;
    tick(); tick();
    check("rst_exe_v", EXE_V, 0);
    check("rst_exe_imm", EXE_IMM, 0);
    check("rst_exe_dr", EXE_DR, 0);
    check("rst_exe_we", EXE_WE, 0);
    check("rst_exe_ir", EXE_IR, 0);
    check("rst_exe_npc", EXE_NPC, 0);
    RESET_N = 1'b1;
    wb(1'b0, 5'd0, 64'h0);

    // x5 must still read 0 after the ignored reset-cycle writeback.
    present(1'b1, add(5'd6, 5'd5, 5'd0), 64'h200);
    #1 check("x5_nostall", V_DEP_STALL, 0);
    tick();
    check("x5_exe_v", EXE_V, 1);
    check("x5_read_zero", EXE_SR1, 0);
    check("x5_exe_dr", EXE_DR, 6);

    // ADDI x1,x0,-1
    present(1'b1, 32'hFFF0_0093, 64'h104);
    tick();
    check("addi_imm", EXE_IMM, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_dr", EXE_DR, 1);
    check("addi_we", EXE_WE, 1);
    check("addi_npc", EXE_NPC, 64'h104);
    check("addi_ir", EXE_IR, 64'hFFF0_0093);

    // LUI x2,0x80000 while x1 retires
    present(1'b1, 32'h8000_0137, 64'h108);
    wb(1'b1, 5'd1, 64'h0);
    tick();
    check("lui_imm", EXE_IMM, 64'hFFFF_FFFF_8000_0000);
    check("lui_dr", EXE_DR, 2);
    check("lui_we", EXE_WE, 1);
    present(1'b0, 32'h0, 64'h0);
    wb(1'b1, 5'd2, 64'h0);
    tick();
    check("bubble_exe_v", EXE_V, 0);
    wb(1'b0, 5'd0, 64'h0);

    // RAW: ADDI x1,x0,5 then ADD x3,x1,x1
    present(1'b1, addi(5'd1, 5'd0, 12'd5), 64'h300);
    #1 check("raw_producer_nostall", V_DEP_STALL, 0);
    tick();
    check("raw_producer_issue", EXE_V, 1);
    present(1'b1, add(5'd3, 5'd1, 5'd1), 64'h304);
    #1 check("raw_stall_c0", V_DEP_STALL, 1);
    tick();
    check("raw_exe_v_c0", EXE_V, 0);
    check("raw_stall_c1", V_DEP_STALL, 1);
    check("raw_hold_imm", EXE_IMM, 5);
    check("raw_hold_dr", EXE_DR, 1);
    tick();
    check("raw_exe_v_c1", EXE_V, 0);
    wb(1'b1, 5'd1, 64'd5);
    #1 check("raw_stall_release", V_DEP_STALL, 0);
    tick();
    check("raw_issue", EXE_V, 1);
    check("raw_sr1", EXE_SR1, 5);
    check("raw_sr2", EXE_SR2, 5);
    check("raw_dr", EXE_DR, 3);

    // Double writer of x4 (x3 retires meanwhile)
    present(1'b1, addi(5'd4, 5'd0, 12'd7), 64'h400);
    wb(1'b1, 5'd3, 64'h33);
    tick();
    present(1'b1, addi(5'd4, 5'd0, 12'd9), 64'h404);
    wb(1'b0, 5'd0, 64'h0);
    #1 check("dw_second_nostall", V_DEP_STALL, 0);
    tick();
    check("dw_second_issue", EXE_V, 1);
    present(1'b1, add(5'd7, 5'd4, 5'd0), 64'h408);
    #1 check("dw_reader_stall", V_DEP_STALL, 1);
    wb(1'b1, 5'd4, 64'd7);
    #1 check("dw_stall_first_wb", V_DEP_STALL, 1);
    tick();
    check("dw_exe_v_after_first", EXE_V, 0);
    wb(1'b0, 5'd0, 64'h0);
    #1 check("dw_stall_between", V_DEP_STALL, 1);
    tick();
    wb(1'b1, 5'd4, 64'd9);
    #1 check("dw_stall_second_wb", V_DEP_STALL, 0);
    tick();
    check("dw_issue", EXE_V, 1);
    check("dw_sr1", EXE_SR1, 9);
    wb(1'b0, 5'd0, 64'h0);

    // BEQ x0,x0,+8
    present(1'b1, 32'h0000_0463, 64'h500);
    #1 check("beq_br_stall", V_DE_FE_BR_STALL, 1);
    check("beq_dep_stall", V_DEP_STALL, 0);
    tick();
    check("beq_imm", EXE_IMM, 8);
    check("beq_we", EXE_WE, 0);
    check("beq_exe_v", EXE_V, 1);
    present(1'b0, 32'h0000_0463, 64'h500);
    #1 check("beq_br_stall_invalid", V_DE_FE_BR_STALL, 0);

    // JAL x1,+16
    present(1'b1, 32'h0100_00EF, 64'h600);
    #1 check("jal_br_stall", V_DE_FE_BR_STALL, 1);
    tick();
    check("jal_imm", EXE_IMM, 16);
    check("jal_we", EXE_WE, 1);
    present(1'b1, 32'h0000_0013, 64'h604);
    wb(1'b1, 5'd1, 64'h604);
    tick();
    wb(1'b0, 5'd0, 64'h0);

    // x0 hazard: ADDI x0,x0,1 then ADD x5,x0,x0 with a writeback aimed at x0
    present(1'b1, 32'h0010_0013, 64'h700);
    tick();
    check("x0_we", EXE_WE, 0);
    present(1'b1, 32'h0000_02B3, 64'h704);
    wb(1'b1, 5'd0, 64'hFF);
    #1 check("x0_nostall", V_DEP_STALL, 0);
    tick();
    check("x0_issue", EXE_V, 1);
    check("x0_sr1", EXE_SR1, 0);
    check("x0_sr2", EXE_SR2, 0);
    wb(1'b0, 5'd0, 64'h0);

    // Unknown opcode
    present(1'b1, 32'hFFFF_FFFF, 64'h800);
    #1 check("unk_dep_stall", V_DEP_STALL, 0);
    check("unk_br_stall", V_DE_FE_BR_STALL, 0);
    tick();
    check("unk_issue", EXE_V, 1);
    check("unk_we", EXE_WE, 0);
    check("unk_imm", EXE_IMM, 0);
`ifdef DECODE_ILLEGAL_CHECK_EN
    check("unk_illegal", EXE_ILLEGAL, 1);
    present(1'b1, addi(5'd8, 5'd0, 12'd1), 64'h804);
    tick();
    check("legal_illegal", EXE_ILLEGAL, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
